// File: rtl/reg_bus_pkg.sv
// Shared definitions for controlling-register bus blocks: FSM encoding and command record.
package reg_bus_pkg;

  // Bus initiator FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } bus_state_e;

  localparam int unsigned CMD_ADDR_WIDTH  = 33;
  localparam int unsigned CMD_WDATA_WIDTH = 33;

  // Command record as stored in the command queue, MSB first
  typedef struct packed {
    logic                       write;
    logic [CMD_ADDR_WIDTH-1:0]  addr;
    logic [CMD_WDATA_WIDTH-1:0] wdata;
  } reg_cmd_t;

  localparam int unsigned CMD_WIDTH = $bits(reg_cmd_t);

  // Width of a {write, addr, wdata} record for arbitrary field widths
  function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned ww);
    return aw + ww + 1;
  endfunction

endpackage

// File: rtl/reg_bus_cmd_fifo.sv
// Synchronous command FIFO; full/empty are registered so cmd_ready comes straight from a flop.
module reg_bus_cmd_fifo
  import reg_bus_pkg::*;
#(
  parameter int unsigned WIDTH = CMD_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Occupancy after this edge; simultaneous push and pop leave it unchanged
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Pointers, occupancy and status flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Entry storage; no reset needed since pointers define validity
  always_ff @(posedge clock) begin
    if (reset && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/reg_bus_initiator.sv
// Register bus master: replays queued commands as single bus transactions, returns read data.
module reg_bus_initiator
  import reg_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = CMD_ADDR_WIDTH,
  parameter int unsigned WDATA_WIDTH  = CMD_WDATA_WIDTH,
  parameter int unsigned RDATA_WIDTH  = 21,
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [WDATA_WIDTH-1:0] cmd_wdata,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic                   write_enable,
  output logic [WDATA_WIDTH-1:0] write_data,
  output logic                   read_enable,
  input  logic [RDATA_WIDTH-1:0] read_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [RDATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0]  rsp_addr,
  output logic                   busy
);

  localparam int unsigned CMD_W = cmd_width(ADDR_WIDTH, WDATA_WIDTH);
  localparam int unsigned LAT_W = 4;

  bus_state_e             state;
  logic [LAT_W-1:0]       lat_cnt;
  logic [CMD_W-1:0]       fifo_din;
  logic [CMD_W-1:0]       fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   head_write;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic [WDATA_WIDTH-1:0] head_wdata;

  assign fifo_din   = {cmd_write, cmd_addr, cmd_wdata};
  assign fifo_push  = cmd_valid & cmd_ready;
  assign fifo_pop   = (state == IDLE) & ~fifo_empty;
  assign head_write = fifo_dout[CMD_W-1];
  assign head_addr  = fifo_dout[WDATA_WIDTH +: ADDR_WIDTH];
  assign head_wdata = fifo_dout[WDATA_WIDTH-1:0];
  assign cmd_ready  = ~fifo_full;
  assign busy       = ~fifo_empty | (state != IDLE);

  reg_bus_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Transaction sequencer with registered bus strobes and response capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      address      <= '0;
      write_enable <= 1'b0;
      write_data   <= '0;
      read_enable  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_addr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            address <= head_addr;
            if (head_write) begin
              write_data   <= head_wdata;
              write_enable <= 1'b1;
              state        <= WR;
            end else begin
              read_enable <= 1'b1;
              lat_cnt     <= LAT_W'(READ_LATENCY);
              state       <= RD;
            end
          end
        end
        WR: begin
          write_enable <= 1'b0;
          state        <= IDLE;
        end
        RD: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else begin
            rsp_rdata   <= read_data;
            rsp_addr    <= address;
            read_enable <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Scoreboard bench for reg_bus_initiator (CMD_DEPTH=4, READ_LATENCY=2).
module tb_reg_bus_initiator;

  localparam int unsigned AW  = 33;
  localparam int unsigned WW  = 33;
  localparam int unsigned RW  = 21;
  localparam int unsigned LAT = 2;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } op_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [RW-1:0] r;
  } rsp_t;

  logic          clock;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [WW-1:0] cmd_wdata;
  logic [AW-1:0] address;
  logic          write_enable;
  logic [WW-1:0] write_data;
  logic          read_enable;
  logic [RW-1:0] read_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_rdata;
  logic [AW-1:0] rsp_addr;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  op_t  op_q[$];
  rsp_t rsp_q[$];
  int   we_starts[$];

  int   last_we_start = -1;
  int   last_rv_start = -1;
  int   rd_len        = 0;
  int   rsp_cycles    = 0;
  int   both_high     = 0;
  logic prev_we       = 1'b0;
  logic prev_re       = 1'b0;
  logic prev_rv       = 1'b0;

  reg_bus_initiator #(
    .ADDR_WIDTH   (AW),
    .WDATA_WIDTH  (WW),
    .RDATA_WIDTH  (RW),
    .CMD_DEPTH    (4),
    .READ_LATENCY (LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .address      (address),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_addr     (rsp_addr),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Responder: data is a fixed function of the address, zero when not reading
  function automatic logic [RW-1:0] resp_f(input logic [AW-1:0] a);
    return 21'h0ABCD ^ a[RW-1:0] ^ 21'h00055;
  endfunction

  assign read_data = read_enable ? resp_f(address) : '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_op(input logic w);
    op_t e;
    check_eq("strobe_excl", 64'(write_enable & read_enable), 64'd0);
    if (op_q.size() == 0) begin
      check_eq("op_unexpected", 64'd1, 64'd0);
    end else begin
      e = op_q.pop_front();
      check_eq("op_kind", 64'(w), 64'(e.w));
      check_eq("op_addr", 64'(address), 64'(e.a));
      if (w) check_eq("op_wdata", 64'(write_data), 64'(e.d));
    end
  endtask

  // Bus and response monitor, sampled on the falling edge
  always @(negedge clock) begin
    rsp_t r;
    if (!reset) begin
      prev_we = 1'b0;
      prev_re = 1'b0;
      prev_rv = 1'b0;
      rd_len  = 0;
    end else begin
      if (write_enable && read_enable) both_high++;
      if (prev_we) check_eq("we_pulse", 64'(write_enable), 64'd0);
      if (write_enable && !prev_we) begin
        we_starts.push_back(cyc);
        last_we_start = cyc;
        sb_op(1'b1);
      end
      if (read_enable) begin
        if (!prev_re) sb_op(1'b0);
        rd_len++;
      end else if (prev_re) begin
        check_eq("re_len", 64'(rd_len), 64'(LAT + 1));
        rd_len = 0;
      end
      if (rsp_valid && !prev_rv) last_rv_start = cyc;
      if (rsp_valid) rsp_cycles++;
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check_eq("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          r = rsp_q.pop_front();
          check_eq("rsp_rdata", 64'(rsp_rdata), 64'(r.r));
          check_eq("rsp_addr", 64'(rsp_addr), 64'(r.a));
        end
      end
      prev_we = write_enable;
      prev_re = read_enable;
      prev_rv = rsp_valid;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one command; returns just after its handshake edge with cmd_valid still high
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [WW-1:0] d, output int hs);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && t < 300) begin
      step();
      t++;
    end
    hs = -100;
    if (!cmd_ready) begin
      check_eq("send_timeout", 64'd1, 64'd0);
      cmd_valid = 1'b0;
    end else begin
      hs = cyc;
      op_q.push_back('{w: w, a: a, d: d});
      if (!w) rsp_q.push_back('{a: a, r: resp_f(a)});
      step();
    end
  endtask

  task automatic drop();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy || rsp_valid) && t < 400) begin
      step();
      t++;
    end
    check_eq({tag, "_idle"}, 64'(busy | rsp_valid), 64'd0);
    check_eq({tag, "_ops_left"}, 64'(op_q.size()), 64'd0);
    check_eq({tag, "_rsp_left"}, 64'(rsp_q.size()), 64'd0);
  endtask

  initial begin
    int hs;
    int hs_rd;
    int t;
    int rsp_before;

    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 33'h0EE;
    cmd_wdata = 33'h0FF;
    rsp_ready = 1'b1;

    // Reset held with a command offered: nothing may be queued
    repeat (3) step();
    check_eq("rst_we", 64'(write_enable), 64'd0);
    check_eq("rst_re", 64'(read_enable), 64'd0);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_address", 64'(address), 64'd0);
    drop();
    reset = 1'b1;
    repeat (3) step();
    check_eq("rst_no_push", 64'(busy), 64'd0);

    // Single write
    rsp_before = rsp_cycles;
    send(1'b1, 33'h0AA, 33'h01234, hs);
    drop();
    wait_idle("wr1");
    check_eq("wr1_latency", 64'(last_we_start), 64'(hs + 2));
    check_eq("wr1_no_rsp", 64'(rsp_cycles - rsp_before), 64'd0);
    check_eq("wr1_addr_hold", 64'(address), 64'h0AA);

    // Single read with latency 2
    send(1'b0, 33'h055, 33'h0, hs);
    drop();
    wait_idle("rd1");
    check_eq("rd1_rsp_latency", 64'(last_rv_start), 64'(hs + 3 + LAT));
    check_eq("rd1_wdata_hold", 64'(write_data), 64'h01234);

    // Stall in RSP, fill the queue, then drain in order
    rsp_ready = 1'b0;
    send(1'b0, 33'h010, 33'h0, hs_rd);
    drop();
    t = 0;
    while (!rsp_valid && t < 50) begin
      step();
      t++;
    end
    check_eq("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    send(1'b1, 33'h101, 33'h1_0000_0001, hs);
    send(1'b0, 33'h1_0000_0102, 33'h0, hs);
    send(1'b1, 33'h103, 33'h0_DEAD_BEEF, hs);
    send(1'b0, 33'h104, 33'h0, hs);
    check_eq("full_cmd_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 33'h105;
    cmd_wdata = 33'h0_0505;
    repeat (3) step();
    check_eq("full_hold_ready", 64'(cmd_ready), 64'd0);
    check_eq("full_no_strobe", 64'(write_enable | read_enable), 64'd0);
    check_eq("full_rsp_stable", 64'(rsp_addr), 64'h010);
    rsp_ready = 1'b1;
    send(1'b1, 33'h105, 33'h0_0505, hs);
    drop();
    wait_idle("drain");

    // Reset while a read is in flight
    send(1'b0, 33'h077, 33'h0, hs);
    drop();
    t = 0;
    while (!read_enable && t < 20) begin
      step();
      t++;
    end
    check_eq("rdrst_in_rd", 64'(read_enable), 64'd1);
    reset = 1'b0;
    step();
    check_eq("rdrst_re", 64'(read_enable), 64'd0);
    check_eq("rdrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rdrst_busy", 64'(busy), 64'd0);
    op_q.delete();
    rsp_q.delete();
    reset = 1'b1;
    rsp_before = rsp_cycles;
    repeat (6) step();
    check_eq("rdrst_rsp_dropped", 64'(rsp_cycles - rsp_before), 64'd0);
    send(1'b1, 33'h099, 33'h0_5A5A, hs);
    drop();
    wait_idle("rdrst_after");
    check_eq("rdrst_after_lat", 64'(last_we_start), 64'(hs + 2));

    // Back-to-back writes with cmd_valid held
    we_starts.delete();
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, AW'(i), WW'(32'h100 + i), hs);
    end
    drop();
    wait_idle("b2b");
    check_eq("b2b_count", 64'(we_starts.size()), 64'd4);
    for (int i = 1; i < we_starts.size(); i++) begin
      check_eq("b2b_gap", 64'(we_starts[i] - we_starts[i-1]), 64'd2);
    end
    check_eq("never_both_high", 64'(both_high), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
